// File: rtl/ram8_arbiter_if.sv
// ----------------------------------------------------------------------------
// ram8_arbiter_if
// One requester's command/response bundle for ram8_arbiter.
//   req    requester -> arbiter  command request, held until granted
//   we     requester -> arbiter  1 = write, 0 = read
//   addr   requester -> arbiter  RAM address
//   wdata  requester -> arbiter  write data
//   gnt    arbiter -> requester  command accepted at the next edge
//   rvalid arbiter -> requester  read data valid (one cycle per read)
//   rdata  arbiter -> requester  read data
// Modports: master = requester side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface ram8_arbiter_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, wdata, input  gnt, rvalid, rdata);
    modport slave  (input  req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/ram8_arbiter.sv
// ----------------------------------------------------------------------------
// ram8_arbiter
// Two-requester front end for an 8x8 synchronous RAM with one write port and
// one read port. At most one command is granted per cycle. A sweep sequencer
// writes INIT_VAL to every location on init_start_i.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   a_if, b_if        requester bundles (ram8_arbiter_if.slave)
//   init_start_i      start a clear sweep (wins over pending requests)
//   init_busy_o       sweep in progress
//   init_done_o       one-cycle pulse alongside the final sweep write
//   ram_wr_enb_o, ram_wr_addr_o, ram_data_in_o   registered RAM write command
//   ram_rd_enb_o, ram_rd_addr_o                  registered RAM read command
//   ram_data_out_i    RAM read data, valid the cycle after ram_rd_enb_o
//
// Build option:
//   RAM8_ARB_FIXED_PRIO_EN  defined   -> port A always wins contention
//                           undefined -> round-robin on the last grant
// ----------------------------------------------------------------------------
module ram8_arbiter #(
    parameter int            DW       = 8,
    parameter int            AW       = 3,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    ram8_arbiter_if.slave a_if,
    ram8_arbiter_if.slave b_if,
    input  logic          init_start_i,
    output logic          init_busy_o,
    output logic          init_done_o,
    output logic          ram_wr_enb_o,
    output logic          ram_rd_enb_o,
    output logic [AW-1:0] ram_wr_addr_o,
    output logic [AW-1:0] ram_rd_addr_o,
    output logic [DW-1:0] ram_data_in_o,
    input  logic [DW-1:0] ram_data_out_i
);

    typedef enum logic { ST_IDLE = 1'b0, ST_INIT = 1'b1 } state_t;
    typedef enum logic { PORT_A  = 1'b0, PORT_B  = 1'b1 } port_t;

    localparam logic [AW-1:0] CNT_LAST = '1;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          wr_enb_q, wr_enb_d;
    logic          rd_enb_q, rd_enb_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [DW-1:0] data_in_q, data_in_d;
    port_t         rd_tag_q, rd_tag_d;   // which port owns the read on the RAM bus
    logic          a_rvalid_q, a_rvalid_d;
    logic          b_rvalid_q, b_rvalid_d;
    logic          done_q, done_d;
`ifndef RAM8_ARB_FIXED_PRIO_EN
    port_t         last_q, last_d;
`endif

    logic a_gnt, b_gnt;
    logic a_acc, b_acc;

    // ------------------------------------------------------------------
    // Grant: combinational from requests, state, init_start and history.
    // NOTE: every always_comb output gets a default first; a path that
    // leaves one unassigned would infer a latch.
    // ------------------------------------------------------------------
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (state_q == ST_IDLE && !init_start_i) begin
            if (a_if.req && !b_if.req) begin
                a_gnt = 1'b1;
            end else if (!a_if.req && b_if.req) begin
                b_gnt = 1'b1;
            end else if (a_if.req && b_if.req) begin
`ifdef RAM8_ARB_FIXED_PRIO_EN
                a_gnt = 1'b1;
`else
                // The port that did not win last time goes first.
                if (last_q == PORT_B) a_gnt = 1'b1;
                else                  b_gnt = 1'b1;
`endif
            end
        end
    end

    assign a_acc = a_if.req & a_gnt;
    assign b_acc = b_if.req & b_gnt;

    // ------------------------------------------------------------------
    // Next state, RAM command and read-return pipeline.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_enb_d  = 1'b0;
        rd_enb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        data_in_d = data_in_q;
        rd_tag_d  = rd_tag_q;
        done_d    = 1'b0;
`ifndef RAM8_ARB_FIXED_PRIO_EN
        last_d    = last_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (init_start_i) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end else if (a_acc) begin
                    wr_enb_d = a_if.we;
                    rd_enb_d = !a_if.we;
                    if (a_if.we) begin
                        wr_addr_d = a_if.addr;
                        data_in_d = a_if.wdata;
                    end else begin
                        rd_addr_d = a_if.addr;
                        rd_tag_d  = PORT_A;
                    end
`ifndef RAM8_ARB_FIXED_PRIO_EN
                    last_d = PORT_A;
`endif
                end else if (b_acc) begin
                    wr_enb_d = b_if.we;
                    rd_enb_d = !b_if.we;
                    if (b_if.we) begin
                        wr_addr_d = b_if.addr;
                        data_in_d = b_if.wdata;
                    end else begin
                        rd_addr_d = b_if.addr;
                        rd_tag_d  = PORT_B;
                    end
`ifndef RAM8_ARB_FIXED_PRIO_EN
                    last_d = PORT_B;
`endif
                end
            end
            ST_INIT: begin
                wr_enb_d  = 1'b1;
                wr_addr_d = cnt_q;
                data_in_d = INIT_VAL;
                cnt_d     = cnt_q + 1'b1;
                // done is registered with the last write so both appear together.
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
        endcase

        // The RAM samples the read at the edge after the command is on the
        // bus, so rvalid is the tagged rd_enb delayed one more edge.
        a_rvalid_d = rd_enb_q && (rd_tag_q == PORT_A);
        b_rvalid_d = rd_enb_q && (rd_tag_q == PORT_B);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values of the others.
    // NOTE: the read tag/valid pipeline is reset so a read in flight when
    // rst_n drops can never surface as rvalid afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            wr_enb_q   <= 1'b0;
            rd_enb_q   <= 1'b0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            data_in_q  <= '0;
            rd_tag_q   <= PORT_A;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_enb_q   <= wr_enb_d;
            rd_enb_q   <= rd_enb_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            data_in_q  <= data_in_d;
            rd_tag_q   <= rd_tag_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            done_q     <= done_d;
        end
    end

`ifndef RAM8_ARB_FIXED_PRIO_EN
    // Reset to B so that A wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= PORT_B;
        else        last_q <= last_d;
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign a_if.gnt    = a_gnt;
    assign b_if.gnt    = b_gnt;
    assign a_if.rvalid = a_rvalid_q;
    assign b_if.rvalid = b_rvalid_q;
    // Gated so rdata is zero whenever no read is being returned.
    assign a_if.rdata  = a_rvalid_q ? ram_data_out_i : '0;
    assign b_if.rdata  = b_rvalid_q ? ram_data_out_i : '0;

    assign init_busy_o   = (state_q == ST_INIT);
    assign init_done_o   = done_q;
    assign ram_wr_enb_o  = wr_enb_q;
    assign ram_rd_enb_o  = rd_enb_q;
    assign ram_wr_addr_o = wr_addr_q;
    assign ram_rd_addr_o = rd_addr_q;
    assign ram_data_in_o = data_in_q;

endmodule
